// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing
// and a saturating count of inserted bubbles.
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [14:0] ctrl_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        uses_rt_i,
    input  logic        flush_i,
    output logic [14:0] ctrl_o,
    output logic [31:0] pc4_o,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs_addr_o,
    output logic [4:0]  rt_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        stall_o,
    output logic [15:0] bubble_cnt_o
);

    logic load_in_ex;
    logic rs_match;
    logic rt_match;
    logic bubble;

    // Load in EX whose destination is read by the ID instruction; $0 never hazards.
    assign load_in_ex = ctrl_o[3] & ctrl_o[14] & (rt_addr_o != 5'd0);
    assign rs_match   = (rt_addr_o == rs_addr_i);
    assign rt_match   = uses_rt_i & (rt_addr_o == rt_addr_i);
    assign stall_o    = load_in_ex & (rs_match | rt_match);
    assign bubble     = flush_i | stall_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_o    <= '0;
            pc4_o     <= '0;
            rs_data_o <= '0;
            rt_data_o <= '0;
            imm_o     <= '0;
            rs_addr_o <= '0;
            rt_addr_o <= '0;
            rd_addr_o <= '0;
        end else if (flush_i) begin
            ctrl_o    <= '0;
            pc4_o     <= '0;
            rs_data_o <= '0;
            rt_data_o <= '0;
            imm_o     <= '0;
            rs_addr_o <= '0;
            rt_addr_o <= '0;
            rd_addr_o <= '0;
        end else begin
            // A stall only zeroes control; data still advances with the bubble.
            ctrl_o    <= stall_o ? '0 : ctrl_i;
            pc4_o     <= pc4_i;
            rs_data_o <= rs_data_i;
            rt_data_o <= rt_data_i;
            imm_o     <= imm_i;
            rs_addr_o <= rs_addr_i;
            rt_addr_o <= rt_addr_i;
            rd_addr_o <= rd_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (bubble && (bubble_cnt_o != '1)) begin
            bubble_cnt_o <= bubble_cnt_o + 16'd1;
        end
    end

endmodule
